// File: rtl/rv_div_pkg.sv
// rv_div_pkg: shared types, constants and special-case helpers for the RV32M divider.
package rv_div_pkg;
   localparam int XLEN = 32;
   localparam int DIV_ITER = 32;
   localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;
   typedef enum logic [1:0] {DIV, DIVU, REM, REMU} div_op_e;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;
   function automatic logic is_special(div_op_e op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
      return b == '0 || ((op == DIV || op == REM) && a == INT_MIN && b == DIV_ZERO_Q);
   endfunction
   function automatic logic [XLEN-1:0] special_res(div_op_e op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
      return b == '0 ? ((op == REM || op == REMU) ? a : DIV_ZERO_Q)
                     : ((op == REM || op == REMU) ? '0 : INT_MIN);
   endfunction
endpackage

// File: rtl/rv_div_unit_if.sv
// rv_div_unit_if: request/result handshake bundle between operand read, divider and writeback.
interface rv_div_unit_if;
   import rv_div_pkg::*;
   logic in_valid;
   logic in_ready;
   div_op_e op;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [4:0] rd_in;
   logic out_valid;
   logic out_ready;
   logic [31:0] result;
   logic [4:0] rd_out;
   modport master (
      output in_valid, op, rs1_val, rs2_val, rd_in, out_ready,
      input in_ready, out_valid, result, rd_out
   );
   modport slave (
      input in_valid, op, rs1_val, rs2_val, rd_in, out_ready,
      output in_ready, out_valid, result, rd_out
   );
endinterface

// File: rtl/rv_div_unit_div_step.sv
// div_step: one radix-2 non-restoring iteration on a 34-bit signed partial remainder.
module div_step (
   input logic [33:0] rem_i,
   input logic [31:0] quo_i,
   input logic [31:0] den_i,
   output logic [33:0] rem_o,
   output logic [31:0] quo_o
);
   logic [33:0] sh;
   assign sh = {rem_i[32:0], quo_i[31]};
   assign rem_o = rem_i[33] ? sh + {2'b0, den_i} : sh - {2'b0, den_i};
   assign quo_o = {quo_i[30:0], ~rem_o[33]};
endmodule

// File: rtl/rv_div_unit.sv
// rv_div_unit: iterative RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_FAST_SPECIAL_EN to resolve divide-by-zero and signed overflow at accept.
module rv_div_unit
   import rv_div_pkg::*;
(
   input logic clk,
   input logic rst_n,
   input logic flush,
   output logic busy,
   rv_div_unit_if.slave io
);
   div_state_e state_q, state_d;
   div_op_e op_q, op_d;
   logic [4:0] cnt_q, cnt_d, rd_q, rd_d;
   logic s1_q, s1_d, s2_q, s2_d, sgn_op;
   logic [31:0] den_q, den_d, quo_q, quo_d, res_q, res_d, step_quo, q_sgn, r_sgn;
   logic [33:0] rem_q, rem_d, step_rem, rem_fix;
   div_step u_step (.rem_i(rem_q), .quo_i(quo_q), .den_i(den_q), .rem_o(step_rem), .quo_o(step_quo));
   assign sgn_op = io.op == DIV || io.op == REM;
   // Non-restoring leaves a negative remainder one divisor short.
   assign rem_fix = rem_q[33] ? rem_q + {2'b0, den_q} : rem_q;
   assign q_sgn = (s1_q ^ s2_q) ? -quo_q : quo_q;
   assign r_sgn = s1_q ? -rem_fix[31:0] : rem_fix[31:0];
   always_comb begin
      state_d = state_q;
      op_d = op_q;
      cnt_d = cnt_q;
      rd_d = rd_q;
      s1_d = s1_q;
      s2_d = s2_q;
      den_d = den_q;
      quo_d = quo_q;
      rem_d = rem_q;
      res_d = res_q;
      if (flush) state_d = IDLE;
      else case (state_q)
         IDLE: if (io.in_valid) begin
            op_d = io.op;
            rd_d = io.rd_in;
            s1_d = sgn_op & io.rs1_val[31];
            s2_d = sgn_op & io.rs2_val[31];
            quo_d = s1_d ? -io.rs1_val : io.rs1_val;
            den_d = s2_d ? -io.rs2_val : io.rs2_val;
            rem_d = '0;
            cnt_d = 5'(DIV_ITER - 1);
            state_d = CALC;
`ifdef DIV_FAST_SPECIAL_EN
            if (is_special(io.op, io.rs1_val, io.rs2_val)) begin
               res_d = special_res(io.op, io.rs1_val, io.rs2_val);
               state_d = DONE;
            end
`endif
         end
         CALC: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q == '0 ? '0 : cnt_q - 5'd1;
            state_d = cnt_q == '0 ? FIX : CALC;
         end
         // Signed overflow falls out of the magnitude math; only DIV by zero needs overriding.
         FIX: begin
            res_d = (op_q == REM || op_q == REMU) ? r_sgn : den_q == '0 ? DIV_ZERO_Q : q_sgn;
            state_d = DONE;
         end
         DONE: if (io.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q <= DIV;
         cnt_q <= '0;
         rd_q <= '0;
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         den_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         res_q <= '0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
         cnt_q <= cnt_d;
         rd_q <= rd_d;
         s1_q <= s1_d;
         s2_q <= s2_d;
         den_q <= den_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
         res_q <= res_d;
      end
   end
   assign io.in_ready = state_q == IDLE;
   assign busy = state_q != IDLE;
   assign io.out_valid = state_q == DONE;
   assign io.result = res_q;
   assign io.rd_out = rd_q;
endmodule

// File: tb/tb_rv_div_unit.sv
// tb_rv_div_unit: directed vectors for rv_div_unit with latency, backpressure, flush and reset checks.
module tb_rv_div_unit;
   import rv_div_pkg::*;
`ifdef DIV_FAST_SPECIAL_EN
   localparam int SPEC_LAT = 1;
`else
   localparam int SPEC_LAT = 34;
`endif
   logic clk, rst_n, flush, busy;
   int pass_cnt = 0, tot_cnt = 0;
   rv_div_unit_if io ();
   rv_div_unit dut (.clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy), .io(io.slave));
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tot_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask
   task automatic start(input div_op_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      @(negedge clk);
      io.op = op;
      io.rs1_val = a;
      io.rs2_val = b;
      io.rd_in = rd;
      io.in_valid = 1'b1;
      @(posedge clk);
      #1;
      io.in_valid = 1'b0;
   endtask
   task automatic wait_done(output int lat);
      lat = 1;
      while (!io.out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask
   task automatic run(input string tag, input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
      int lat;
      start(op, a, b, rd);
      wait_done(lat);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_res"}, io.result, exp);
      check({tag, "_rd"}, 32'(io.rd_out), 32'(rd));
      @(posedge clk);
      #1;
      check({tag, "_idle"}, 32'(io.in_ready), 32'd1);
   endtask
   initial begin
      int lat;
      logic seen;
      rst_n = 1'b0;
      flush = 1'b0;
      io.in_valid = 1'b0;
      io.out_ready = 1'b1;
      io.op = DIV;
      io.rs1_val = '0;
      io.rs2_val = '0;
      io.rd_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(io.in_ready), 32'd1);
      check("rst_out_valid", 32'(io.out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_result", io.result, 32'd0);
      check("rst_rd", 32'(io.rd_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run("divu_100_7", DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 34);
      run("remu_100_7", REMU, 32'd100, 32'd7, 5'd3, 32'd2, 34);
      run("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 34);
      run("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 34);
      run("divu_max_max", DIVU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd6, 32'd0, 34);
      run("remu_max_max", REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 34);
      run("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'hFFFF_FFFF, 34);
      run("div_5_0", DIV, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, SPEC_LAT);
      run("remu_5_0", REMU, 32'd5, 32'd0, 5'd9, 32'd5, SPEC_LAT);
      run("div_m5_0", DIV, 32'hFFFF_FFFB, 32'd0, 5'd10, 32'hFFFF_FFFF, SPEC_LAT);
      run("rem_m5_0", REM, 32'hFFFF_FFFB, 32'd0, 5'd11, 32'hFFFF_FFFB, SPEC_LAT);
      run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, SPEC_LAT);
      run("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, SPEC_LAT);
      io.out_ready = 1'b0;
      start(DIVU, 32'd100, 32'd7, 5'd5);
      wait_done(lat);
      check("bp_lat", 32'(lat), 32'd34);
      repeat (10) begin
         @(posedge clk);
         #1;
         check("bp_valid", 32'(io.out_valid), 32'd1);
         check("bp_result", io.result, 32'd14);
         check("bp_rd", 32'(io.rd_out), 32'd5);
         check("bp_in_ready", 32'(io.in_ready), 32'd0);
      end
      @(negedge clk);
      io.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", 32'(io.out_valid), 32'd0);
      check("bp_release_ready", 32'(io.in_ready), 32'd1);
      @(negedge clk);
      io.op = DIVU;
      io.rs1_val = 32'd50;
      io.rs2_val = 32'd5;
      io.in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      io.in_valid = 1'b0;
      flush = 1'b0;
      check("flush_vs_accept_busy", 32'(busy), 32'd0);
      start(DIV, 32'd1000, 32'd3, 5'd7);
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_in_ready", 32'(io.in_ready), 32'd1);
      check("flush_busy", 32'(busy), 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         seen |= io.out_valid;
      end
      check("flush_no_valid", 32'(seen), 32'd0);
      run("divu_9_3", DIVU, 32'd9, 32'd3, 5'd12, 32'd3, 34);
      start(DIV, 32'd1000, 32'd3, 5'd9);
      repeat (19) @(posedge clk);
      #1;
      check("pre_rst_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(io.out_valid), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_ready", 32'(io.in_ready), 32'd1);
      check("async_rst_rd", 32'(io.rd_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run("div_m8_m2", DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 5'd4, 32'd4, 34);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
